alu_exec_stage: RTL and testbench

//  Execution stage directly downstream of the reservation station.

---
 rtl/alu_exec_stage.sv | 129 ++++++++++++
 tb/tb_alu_exec_stage.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_stage.sv
// RV32I integer execution stage: computes one issued op per cycle and queues
// tagged results in a small FIFO that drives the ALU CDB broadcast.
module alu_exec_stage #(
  parameter int DATA_W     = 32,
  parameter int ROB_W      = 5,
  parameter int OP_W       = 6,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              flush,
  input  logic [OP_W-1:0]   in_op,
  input  logic [DATA_W-1:0] in_Vj,
  input  logic [DATA_W-1:0] in_Vk,
  input  logic [DATA_W-1:0] in_imm,
  input  logic [DATA_W-1:0] in_pc,
  input  logic [ROB_W-1:0]  in_rob_tag,
  output logic              in_ready,
  input  logic              cdb_grant,
  output logic              cdb_valid,
  output logic [ROB_W-1:0]  cdb_rob_tag,
  output logic [DATA_W-1:0] cdb_data
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [ROB_W-1:0] ZERO_ROB = '0;

  localparam logic [OP_W-1:0] OP_NOP   = OP_W'(0);
  localparam logic [OP_W-1:0] OP_ADD   = OP_W'(1);
  localparam logic [OP_W-1:0] OP_SUB   = OP_W'(2);
  localparam logic [OP_W-1:0] OP_AND   = OP_W'(3);
  localparam logic [OP_W-1:0] OP_OR    = OP_W'(4);
  localparam logic [OP_W-1:0] OP_XOR   = OP_W'(5);
  localparam logic [OP_W-1:0] OP_SLT   = OP_W'(6);
  localparam logic [OP_W-1:0] OP_SLTU  = OP_W'(7);
  localparam logic [OP_W-1:0] OP_SLL   = OP_W'(8);
  localparam logic [OP_W-1:0] OP_SRL   = OP_W'(9);
  localparam logic [OP_W-1:0] OP_SRA   = OP_W'(10);
  localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(11);
  localparam logic [OP_W-1:0] OP_ANDI  = OP_W'(12);
  localparam logic [OP_W-1:0] OP_ORI   = OP_W'(13);
  localparam logic [OP_W-1:0] OP_XORI  = OP_W'(14);
  localparam logic [OP_W-1:0] OP_SLTI  = OP_W'(15);
  localparam logic [OP_W-1:0] OP_SLTIU = OP_W'(16);
  localparam logic [OP_W-1:0] OP_SLLI  = OP_W'(17);
  localparam logic [OP_W-1:0] OP_SRLI  = OP_W'(18);
  localparam logic [OP_W-1:0] OP_SRAI  = OP_W'(19);
  localparam logic [OP_W-1:0] OP_LUI   = OP_W'(20);
  localparam logic [OP_W-1:0] OP_AUIPC = OP_W'(21);
  localparam logic [OP_W-1:0] OP_JAL   = OP_W'(22);
  localparam logic [OP_W-1:0] OP_JALR  = OP_W'(23);

  logic [DATA_W-1:0] data_q [FIFO_DEPTH];
  logic [ROB_W-1:0]  tag_q  [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;
  logic [DATA_W-1:0] result;
  logic              push;
  logic              pop;

  always_comb begin
    result = '0;
    case (in_op)
      OP_ADD:   result = in_Vj + in_Vk;
      OP_SUB:   result = in_Vj - in_Vk;
      OP_AND:   result = in_Vj & in_Vk;
      OP_OR:    result = in_Vj | in_Vk;
      OP_XOR:   result = in_Vj ^ in_Vk;
      OP_SLT:   result = {{(DATA_W-1){1'b0}}, ($signed(in_Vj) < $signed(in_Vk))};
      OP_SLTU:  result = {{(DATA_W-1){1'b0}}, (in_Vj < in_Vk)};
      OP_SLL:   result = in_Vj << in_Vk[4:0];
      OP_SRL:   result = in_Vj >> in_Vk[4:0];
      OP_SRA:   result = $signed(in_Vj) >>> in_Vk[4:0];
      OP_ADDI:  result = in_Vj + in_imm;
      OP_ANDI:  result = in_Vj & in_imm;
      OP_ORI:   result = in_Vj | in_imm;
      OP_XORI:  result = in_Vj ^ in_imm;
      OP_SLTI:  result = {{(DATA_W-1){1'b0}}, ($signed(in_Vj) < $signed(in_imm))};
      OP_SLTIU: result = {{(DATA_W-1){1'b0}}, (in_Vj < in_imm)};
      OP_SLLI:  result = in_Vj << in_imm[4:0];
      OP_SRLI:  result = in_Vj >> in_imm[4:0];
      OP_SRAI:  result = $signed(in_Vj) >>> in_imm[4:0];
      OP_LUI:   result = in_imm;
      OP_AUIPC: result = in_pc + in_imm;
      OP_JAL,
      OP_JALR:  result = in_pc + DATA_W'(4);
      default:  result = '0;
    endcase
  end

  // Handshake: an issue transfers when in_op != NOP and in_ready=1 (in_ready
  // depends on count only); a result transfers when cdb_valid=1 and cdb_grant=1.
  // Both are qualified by ena and suppressed by flush.
  assign in_ready    = (count != FULL_CNT);
  assign cdb_valid   = (count != '0);
  assign cdb_rob_tag = cdb_valid ? tag_q[rd_ptr]  : ZERO_ROB;
  assign cdb_data    = cdb_valid ? data_q[rd_ptr] : '0;

  assign push = ena & in_ready & (in_op != OP_NOP) & (in_rob_tag != ZERO_ROB) & ~flush;
  assign pop  = ena & cdb_valid & cdb_grant & ~flush;

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (ena) begin
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) begin
          data_q[wr_ptr] <= result;
          tag_q[wr_ptr]  <= in_rob_tag;
          wr_ptr         <= wr_ptr + PTR_W'(1);
        end
        if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
        if (push && !pop)      count <= count + CNT_W'(1);
        else if (pop && !push) count <= count - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed bench for alu_exec_stage: driver pushes expected CDB results into a
// queue, an independent monitor pops and compares on every granted broadcast.
module tb_alu_exec_stage;

  localparam logic [5:0] NOP = 6'd0, ADD = 6'd1, SUB = 6'd2, AND_ = 6'd3, OR_ = 6'd4,
    XOR_ = 6'd5, SLT = 6'd6, SLTU = 6'd7, SLL = 6'd8, SRL = 6'd9, SRA = 6'd10,
    ADDI = 6'd11, ANDI = 6'd12, ORI = 6'd13, XORI = 6'd14, SLTI = 6'd15,
    SLTIU = 6'd16, SLLI = 6'd17, SRLI = 6'd18, SRAI = 6'd19, LUI = 6'd20,
    AUIPC = 6'd21, JAL = 6'd22, JALR = 6'd23;

  logic        clk, rst, ena, flush, cdb_grant;
  logic [5:0]  in_op;
  logic [31:0] in_Vj, in_Vk, in_imm, in_pc;
  logic [4:0]  in_rob_tag;
  logic        in_ready, cdb_valid;
  logic [4:0]  cdb_rob_tag;
  logic [31:0] cdb_data;

  logic [36:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  bit mon_on   = 0;

  alu_exec_stage dut (
    .clk(clk), .rst(rst), .ena(ena), .flush(flush),
    .in_op(in_op), .in_Vj(in_Vj), .in_Vk(in_Vk), .in_imm(in_imm), .in_pc(in_pc),
    .in_rob_tag(in_rob_tag), .in_ready(in_ready), .cdb_grant(cdb_grant),
    .cdb_valid(cdb_valid), .cdb_rob_tag(cdb_rob_tag), .cdb_data(cdb_data)
  );

  // clock / reset
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // driver
  task automatic issue(input logic [5:0] op, input logic [31:0] vj, vk, imm, pc,
                       input logic [4:0] tag, input logic [31:0] exp, input bit acc);
    in_op = op; in_Vj = vj; in_Vk = vk; in_imm = imm; in_pc = pc; in_rob_tag = tag;
    if (acc) exp_q.push_back({tag, exp});
    @(posedge clk); #1;
    in_op = NOP; in_rob_tag = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (mon_on) begin
      if (cdb_valid) begin
        if (cdb_grant && ena) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_bcast_tag", {27'd0, cdb_rob_tag}, 32'd0);
          end else begin
            logic [36:0] item;
            item = exp_q.pop_front();
            chk("cdb_tag", {27'd0, cdb_rob_tag}, {27'd0, item[36:32]});
            chk("cdb_data", cdb_data, item[31:0]);
          end
        end
      end else begin
        chk("idle_tag", {27'd0, cdb_rob_tag}, 32'd0);
        chk("idle_data", cdb_data, 32'd0);
      end
    end
  end

  typedef struct {
    logic [5:0]  op;
    logic [31:0] vj, vk, imm, pc;
    logic [4:0]  tag;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[24];

  initial begin
    vecs[0]  = '{ADD,   32'd5,          32'd7,          32'h13579BDF, 32'h0,        5'd3,  32'd12};
    vecs[1]  = '{SRA,   32'h80000000,   32'h21,         32'h13579BDF, 32'h0,        5'd4,  32'hC0000000};
    vecs[2]  = '{SLTU,  32'd1,          32'hFFFFFFFF,   32'h13579BDF, 32'h0,        5'd5,  32'd1};
    vecs[3]  = '{SLT,   32'd1,          32'hFFFFFFFF,   32'h13579BDF, 32'h0,        5'd7,  32'd0};
    vecs[4]  = '{SUB,   32'd3,          32'd5,          32'h13579BDF, 32'h0,        5'd8,  32'hFFFFFFFE};
    vecs[5]  = '{AND_,  32'hF0F0F0F0,   32'h0FF00FF0,   32'h13579BDF, 32'h0,        5'd10, 32'h00F000F0};
    vecs[6]  = '{OR_,   32'h0F000000,   32'h000000F0,   32'h13579BDF, 32'h0,        5'd11, 32'h0F0000F0};
    vecs[7]  = '{XOR_,  32'hFFFF0000,   32'h0F0F0F0F,   32'h13579BDF, 32'h0,        5'd12, 32'hF0F00F0F};
    vecs[8]  = '{SLL,   32'd1,          32'h25,         32'h13579BDF, 32'h0,        5'd13, 32'h20};
    vecs[9]  = '{SRL,   32'h80000000,   32'd4,          32'h13579BDF, 32'h0,        5'd14, 32'h08000000};
    vecs[10] = '{ADDI,  32'd10,         32'hDEADBEEF,   32'hFFFFFFFF, 32'h0,        5'd15, 32'd9};
    vecs[11] = '{SLTI,  32'hFFFFFFFE,   32'hDEADBEEF,   32'hFFFFFFFF, 32'h0,        5'd16, 32'd1};
    vecs[12] = '{SLTIU, 32'd5,          32'hDEADBEEF,   32'd3,        32'h0,        5'd17, 32'd0};
    vecs[13] = '{XORI,  32'hAAAA5555,   32'hDEADBEEF,   32'hFFFFFFFF, 32'h0,        5'd18, 32'h5555AAAA};
    vecs[14] = '{ANDI,  32'h12345678,   32'hDEADBEEF,   32'h000000FF, 32'h0,        5'd19, 32'h78};
    vecs[15] = '{ORI,   32'h00000100,   32'hDEADBEEF,   32'h0000000F, 32'h0,        5'd20, 32'h10F};
    vecs[16] = '{SLLI,  32'd3,          32'hDEADBEEF,   32'd4,        32'h0,        5'd21, 32'h30};
    vecs[17] = '{SRLI,  32'hF0000000,   32'hDEADBEEF,   32'h1C,       32'h0,        5'd22, 32'hF};
    vecs[18] = '{SRAI,  32'hF0000000,   32'hDEADBEEF,   32'd4,        32'h0,        5'd23, 32'hFF000000};
    vecs[19] = '{LUI,   32'h11111111,   32'hDEADBEEF,   32'hABCDE000, 32'h500,      5'd24, 32'hABCDE000};
    vecs[20] = '{AUIPC, 32'h11111111,   32'hDEADBEEF,   32'h00002000, 32'h1000,     5'd25, 32'h3000};
    vecs[21] = '{JAL,   32'h11111111,   32'hDEADBEEF,   32'h00000040, 32'h100,      5'd9,  32'h104};
    vecs[22] = '{JALR,  32'h11111111,   32'hDEADBEEF,   32'h00000040, 32'hFFFFFFFC, 5'd26, 32'h0};
    vecs[23] = '{6'd63, 32'h11111111,   32'h22222222,   32'h33333333, 32'h44444444, 5'd27, 32'h0};

    rst = 0; ena = 1; flush = 0; cdb_grant = 0;
    in_op = NOP; in_Vj = 0; in_Vk = 0; in_imm = 0; in_pc = 0; in_rob_tag = 0;

    // 1: reset hold
    @(posedge clk);
    mon_on = 1;
    repeat (2) begin
      @(negedge clk);
      chk("rst_valid", {31'd0, cdb_valid}, 32'd0);
      chk("rst_tag", {27'd0, cdb_rob_tag}, 32'd0);
      chk("rst_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk);
    end
    #1 rst = 1;
    idle(1);

    // 2: single ADD with immediate grant
    cdb_grant = 1;
    issue(ADD, 32'd5, 32'd7, 32'h0, 32'h0, 5'd3, 32'd12, 1);
    @(negedge clk);
    chk("t2_valid", {31'd0, cdb_valid}, 32'd1);
    @(negedge clk);
    chk("t2_valid_after", {31'd0, cdb_valid}, 32'd0);
    chk("t2_tag_after", {27'd0, cdb_rob_tag}, 32'd0);
    @(posedge clk); #1;

    // 3: operation table, back-to-back issue with grant held
    for (int i = 0; i < 24; i++)
      issue(vecs[i].op, vecs[i].vj, vecs[i].vk, vecs[i].imm, vecs[i].pc,
            vecs[i].tag, vecs[i].exp, 1);
    idle(3);

    // 4: backpressure and in-order drain
    cdb_grant = 0;
    issue(ADD, 32'd1, 32'd1, 32'h0, 32'h0, 5'd1, 32'd2, 1);
    issue(SUB, 32'd9, 32'd4, 32'h0, 32'h0, 5'd2, 32'd5, 1);
    @(negedge clk);
    chk("t4_ready_full", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    issue(ADD, 32'd7, 32'd7, 32'h0, 32'h0, 5'd28, 32'd14, 0);
    @(negedge clk);
    chk("t4_head_hold", {27'd0, cdb_rob_tag}, 32'd1);
    @(posedge clk); #1;
    cdb_grant = 1;
    issue(ADD, 32'd8, 32'd8, 32'h0, 32'h0, 5'd29, 32'd16, 0);
    idle(2);
    @(negedge clk);
    chk("t4_ready_back", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;

    // 5: flush while full drops queue and the same-cycle issue
    cdb_grant = 0;
    issue(ADD, 32'd2, 32'd2, 32'h0, 32'h0, 5'd1, 32'd4, 1);
    issue(ADD, 32'd3, 32'd3, 32'h0, 32'h0, 5'd2, 32'd6, 1);
    flush = 1;
    issue(ADD, 32'd4, 32'd4, 32'h0, 32'h0, 5'd6, 32'd8, 0);
    flush = 0;
    exp_q.delete();
    @(negedge clk);
    chk("t5_valid", {31'd0, cdb_valid}, 32'd0);
    chk("t5_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    cdb_grant = 1;
    idle(3);

    // 6: untagged op is not queued; reset mid-queue clears entries
    issue(ADDI, 32'd1, 32'h0, 32'd1, 32'h0, 5'd0, 32'd2, 0);
    idle(2);
    cdb_grant = 0;
    issue(ADD, 32'd5, 32'd5, 32'h0, 32'h0, 5'd30, 32'd10, 1);
    issue(ADD, 32'd6, 32'd6, 32'h0, 32'h0, 5'd31, 32'd12, 1);
    rst = 0;
    @(posedge clk); #1;
    rst = 1;
    exp_q.delete();
    @(negedge clk);
    chk("t6_rst_valid", {31'd0, cdb_valid}, 32'd0);
    chk("t6_rst_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    cdb_grant = 1;
    idle(3);

    @(negedge clk);
    chk("drain_empty", exp_q.size(), 32'd0);
    mon_on = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
